// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_responder_pkg;

    localparam int DEPTH_DEFAULT = 256;   // words of storage
    localparam int WAIT_DEFAULT  = 1;     // wait cycles before ack
    localparam int DATA_W        = 32;
    localparam int CNT_W         = 4;     // holds WAIT-1 for WAIT up to 15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // An access is accepted only when word aligned and inside the array.
    function automatic logic addr_ok(input logic [31:0] adr, input int unsigned depth);
        return (adr[1:0] == 2'b00) && ({2'b00, adr[31:2]} < 32'(depth));
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous SRAM, DEPTH x 32. Read data holds until the next read.
module sram_1rw
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array write port; contents are intentionally never reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: loads only on a read so the last read value is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request, waits WAIT cycles, then performs the
// array access and pulses ack (with err for misaligned/out-of-range accesses).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT  = WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       adr,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              ack,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        adr_q, adr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               rd_valid_q, rd_valid_d;

    logic [31:0]        acc_adr_s;
    logic               acc_we_s;
    logic [DATA_W-1:0]  acc_wdata_s;
    logic               acc_ok_s;
    logic               go_resp_s;
    logic               mem_en_s;
    logic [DATA_W-1:0]  sram_rdata_s;

    // Access source: with WAIT=0 the access happens on the capture edge, so the
    // values being captured are used directly; otherwise the captured copies.
    always_comb begin
        acc_adr_s   = adr_q;
        acc_we_s    = we_q;
        acc_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_adr_s   = adr;
            acc_we_s    = MemWrite;
            acc_wdata_s = writedata;
        end else begin
            acc_adr_s   = adr_q;
            acc_we_s    = we_q;
            acc_wdata_s = wdata_q;
        end
        acc_ok_s = addr_ok(acc_adr_s, DEPTH);
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, plus response outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        go_resp_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d   = adr;
                    we_d    = MemWrite;
                    wdata_d = writedata;
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT - 1);
                    end else begin
                        state_d   = ST_RESP;
                        go_resp_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        mem_en_s   = go_resp_s && acc_ok_s;
        ack_d      = go_resp_s;
        err_d      = go_resp_s && !acc_ok_s;
        rd_valid_d = rd_valid_q;
        if (go_resp_s) begin
            if (!acc_ok_s) begin
                rd_valid_d = 1'b0;
            end else if (!acc_we_s) begin
                rd_valid_d = 1'b1;
            end else begin
                rd_valid_d = rd_valid_q;
            end
        end else begin
            rd_valid_d = rd_valid_q;
        end
    end

    // State, counter, capture and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            adr_q      <= 32'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (mem_en_s),
        .we_i    (acc_we_s),
        .addr_i  (acc_adr_s[AW+1:2]),
        .wdata_i (acc_wdata_s),
        .rdata_o (sram_rdata_s)
    );

    // readdata is the held SRAM read register, forced to zero after a
    // rejected access or reset until the next valid read completes.
    assign readdata = sram_rdata_s & {DATA_W{rd_valid_q}};
    assign ack      = ack_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder with WAIT = 1, 0 and 3.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_s       [3];
    logic [31:0] adr_s       [3];
    logic        we_s        [3];
    logic [31:0] wdata_s     [3];
    logic [31:0] readdata_s  [3];
    logic        ack_s       [3];
    logic        err_s       [3];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // index 0: WAIT=1, index 1: WAIT=0, index 2: WAIT=3 (all DEPTH=256)
    mem_responder #(.DEPTH(256), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst), .req(req_s[0]), .adr(adr_s[0]), .MemWrite(we_s[0]),
        .writedata(wdata_s[0]), .readdata(readdata_s[0]), .ack(ack_s[0]), .err(err_s[0]));
    mem_responder #(.DEPTH(256), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req_s[1]), .adr(adr_s[1]), .MemWrite(we_s[1]),
        .writedata(wdata_s[1]), .readdata(readdata_s[1]), .ack(ack_s[1]), .err(err_s[1]));
    mem_responder #(.DEPTH(256), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .req(req_s[2]), .adr(adr_s[2]), .MemWrite(we_s[2]),
        .writedata(wdata_s[2]), .readdata(readdata_s[2]), .ack(ack_s[2]), .err(err_s[2]));

    typedef struct {
        int          inst;
        bit          we;
        logic [31:0] adr;
        logic [31:0] adr_late;  // address driven after the sampling edge
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;   // negedges after the sampling edge until ack
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int inst, bit we, logic [31:0] adr, logic [31:0] adr_late,
                                logic [31:0] wdata, logic [31:0] exp_rd, bit exp_err, int exp_lat);
        vec_t v;
        v.inst = inst; v.we = we; v.adr = adr; v.adr_late = adr_late; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  k;
        int  lat;
        bit  seen;
        string tag;
        k    = v.inst;
        lat  = 99;
        seen = 1'b0;
        tag  = $sformatf("vec%0d", idx);
        @(negedge clk);
        req_s[k]   = 1'b1;
        we_s[k]    = v.we;
        adr_s[k]   = v.adr;
        wdata_s[k] = v.wdata;
        @(posedge clk);
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) adr_s[k] = v.adr_late;
            if (ack_s[k] === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_err"}, {31'd0, err_s[k]}, {31'd0, v.exp_err});
        check({tag, "_rd"}, readdata_s[k], v.exp_rd);
        req_s[k] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, {31'd0, ack_s[k]}, 32'd0);
    endtask

    initial begin
        bit bad;
        for (int k = 0; k < 3; k++) begin
            req_s[k] = 1'b0; adr_s[k] = 32'd0; we_s[k] = 1'b0; wdata_s[k] = 32'd0;
        end

        // WAIT=0 instance
        vecs.push_back(mk(1, 1'b1, 32'h0,   32'h0,   32'h1111_1111, 32'h0,         1'b0, 1));
        vecs.push_back(mk(1, 1'b0, 32'h0,   32'h0,   32'h0,         32'h1111_1111, 1'b0, 1));
        // WAIT=1 instance
        vecs.push_back(mk(0, 1'b1, 32'h10,  32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 32'h10,  32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 32'h0,   32'h0,   32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 32'h2,   32'h2,   32'h0,         32'h0,         1'b1, 2));
        vecs.push_back(mk(0, 1'b1, 32'h400, 32'h400, 32'h5A5A_5A5A, 32'h0,         1'b1, 2));
        vecs.push_back(mk(0, 1'b0, 32'h0,   32'h0,   32'h0,         32'hA5A5_A5A5, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 32'h3FC, 32'h3FC, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 32'h3FC, 32'h3FC, 32'h0,         32'h1234_5678, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 32'h3FF, 32'h3FF, 32'h0,         32'h0,         1'b1, 2));
        vecs.push_back(mk(0, 1'b1, 32'h10,  32'h10,  32'hCCCC_0000, 32'h0,         1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 32'h10,  32'h10,  32'h0,         32'hCCCC_0000, 1'b0, 2));
        // WAIT=3 instance, including address changes after capture
        vecs.push_back(mk(2, 1'b1, 32'h20,  32'h20,  32'h0BAD_F00D, 32'h0,         1'b0, 4));
        vecs.push_back(mk(2, 1'b1, 32'h24,  32'h24,  32'h2424_2424, 32'h0,         1'b0, 4));
        vecs.push_back(mk(2, 1'b0, 32'h20,  32'h24,  32'h0,         32'h0BAD_F00D, 1'b0, 4));
        vecs.push_back(mk(2, 1'b1, 32'h8,   32'h8,   32'h1111_2222, 32'h0BAD_F00D, 1'b0, 4));
        vecs.push_back(mk(2, 1'b1, 32'h20,  32'h24,  32'h9999_9999, 32'h0BAD_F00D, 1'b0, 4));
        vecs.push_back(mk(2, 1'b0, 32'h20,  32'h20,  32'h0,         32'h9999_9999, 1'b0, 4));
        vecs.push_back(mk(2, 1'b0, 32'h24,  32'h24,  32'h0,         32'h2424_2424, 1'b0, 4));

        // Reset state
        #2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ack%0d", k), {31'd0, ack_s[k]}, 32'd0);
            check($sformatf("rst_err%0d", k), {31'd0, err_s[k]}, 32'd0);
            check($sformatf("rst_rd%0d", k), readdata_s[k], 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle with req low: no ack, readdata stays zero
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (ack_s[k] !== 1'b0 || readdata_s[k] !== 32'd0) bad = 1'b1;
            end
        end
        check("idle_quiet", {31'd0, bad}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // WAIT=0 back-to-back reads with req held: ack every second cycle
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; adr_s[1] = 32'h0;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ack%0d", i), {31'd0, ack_s[1]}, {31'd0, (i % 2) == 1});
        end
        req_s[1] = 1'b0;
        check("b2b_rd", readdata_s[1], 32'h1111_1111);

        // WAIT=3: reset while a write to 0x8 is waiting
        @(negedge clk);
        req_s[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 32'h8; wdata_s[2] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        check("mid_wait_ack", {31'd0, ack_s[2]}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_rd", readdata_s[2], 32'd0);
        check("async_rst_ack", {31'd0, ack_s[2]}, 32'd0);
        check("async_rst_err", {31'd0, err_s[2]}, 32'd0);
        check("async_rst_rd_w1", readdata_s[0], 32'd0);
        @(negedge clk);
        req_s[2] = 1'b0;
        rst = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack_s[2] !== 1'b0 || err_s[2] !== 1'b0) bad = 1'b1;
        end
        check("no_ack_after_rst", {31'd0, bad}, 32'd0);
        run_vec(mk(2, 1'b0, 32'h8, 32'h8, 32'h0, 32'h1111_2222, 1'b0, 4), 100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit words of storage (power of two, 16..4096).
REQ-002 Parameter WAIT, default 1, SHALL set the number of wait cycles inserted before ack (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  1  SHALL be the initiator request; held with adr/MemWrite/writedata stable until ack.
REQ-006 adr  input  32  SHALL be the byte address of the access.
REQ-007 MemWrite  input  1  SHALL select write (1) or read (0).
REQ-008 writedata  input  32  SHALL be the write data.
REQ-009 readdata  output  32  SHALL be the registered read data.
REQ-010 ack  output  1  SHALL be a one-cycle pulse that completes a transaction.
REQ-011 err  output  1  SHALL be a one-cycle pulse, coincident with ack, that flags a rejected access.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, RESP.
REQ-013 In IDLE, req=1 SHALL capture adr, MemWrite and writedata into internal registers. The next state SHALL be WAIT with the counter loaded to WAIT-1 when WAIT>0, else RESP.
REQ-014 In WAIT, the counter SHALL decrement each cycle and SHALL go to RESP on the edge where it equals 0.
REQ-015 The array access SHALL occur on the edge entering RESP, using captured values only; adr/MemWrite/writedata changes after capture SHALL be ignored.
REQ-016 ack SHALL be 1 only in RESP. ack rises exactly WAIT+1 cycles after the edge that sampled req. RESP SHALL always return to IDLE.
REQ-017 req SHALL be ignored in WAIT and RESP. A req still high in the IDLE cycle after RESP SHALL start a new transaction, giving a minimum transaction spacing of WAIT+2 cycles.
REQ-018 Word index SHALL be adr[31:2]. An access is rejected when adr[1:0]!=0 or when adr[31:2] >= DEPTH.
REQ-019 Valid read: readdata SHALL load mem[adr[31:2]] on the edge entering RESP and hold it until the next valid read completes.
REQ-020 Valid write: mem[adr[31:2]] SHALL take writedata on the edge entering RESP, and readdata SHALL be unchanged.
REQ-021 Rejected access: there SHALL be no array write, readdata SHALL load 0, and err=1 with ack.
REQ-022 A read immediately following a write to the same word SHALL return the new data.

Reset
REQ-023 rst=0 SHALL force IDLE, counter 0, readdata 0, ack 0, err 0, asynchronously.
REQ-024 Reset during WAIT SHALL discard the pending transaction, so no array write occurs. No ack SHALL be issued for the discarded transaction.
REQ-025 Array contents SHALL NOT be reset.
REQ-026 The first req SHALL be sampled on the first rising edge after rst deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (IDLE/WAIT/RESP) and the constants for the DEPTH and WAIT defaults.
REQ-028 Storage SHALL be one sub-module, sram_1rw: single port, synchronous read/write, DEPTH x 32.
REQ-029 The FSM, counter, capture registers and range check SHALL stay in mem_responder.

Verification
REQ-030 WAIT=1: write adr=0x10, data=0xDEADBEEF -> ack at cycle 2 after sample, err=0. Then read 0x10 -> readdata=0xDEADBEEF with ack.
REQ-031 WAIT=0: write 0x0 = 0x11111111, read 0x0 -> each ack exactly 1 cycle after sample. Back-to-back with req held high -> ack every 2 cycles.
REQ-032 Read adr=0x2 (misaligned), then write to adr=0x400 with DEPTH=256 -> ack+err each time. readdata=0 and mem[0] unchanged.
REQ-033 WAIT=3: change adr from 0x20 to 0x24 during WAIT -> access uses 0x20. ack arrives 4 cycles after sample.
REQ-034 WAIT=3: assert rst=0 during WAIT of write 0x8 = 0xCAFEF00D -> ack/err/readdata go to 0 immediately, no ack follows, and a later read of 0x8 returns the pre-reset value.
REQ-035 Hold req=0 for 10 cycles after reset -> ack never asserts and readdata stays 0.
